// File: rtl/mem_burst_master_if.sv
// rtl/mem_burst_master_if.sv - client command/data streams and memory request port of mem_burst_master
interface mem_burst_master_if #(
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned DATA_SIZE    = 32
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [ADDRESS_SIZE-1:0] cmd_addr;
  logic                    cmd_wr;
  logic [1:0]              cmd_size;

  logic                    wdata_valid;
  logic                    wdata_ready;
  logic [DATA_SIZE-1:0]    wdata;

  logic                    rdata_valid;
  logic                    rdata_ready;
  logic [DATA_SIZE-1:0]    rdata;
  logic                    rdata_last;

  logic                    done;
  logic                    err;

  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0]    mem_wdata;
  logic [1:0]              mem_acc_size;
  logic                    mem_wren;
  logic                    mem_en;
  logic [DATA_SIZE-1:0]    mem_rdata;
  logic                    mem_busy;

  modport master (
    input  cmd_valid, cmd_addr, cmd_wr, cmd_size,
    output cmd_ready,
    input  wdata_valid, wdata,
    output wdata_ready,
    output rdata_valid, rdata, rdata_last,
    input  rdata_ready,
    output done, err,
    output mem_addr, mem_wdata, mem_acc_size, mem_wren, mem_en,
    input  mem_rdata, mem_busy
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_wr, cmd_size,
    input  cmd_ready,
    output wdata_valid, wdata,
    input  wdata_ready,
    input  rdata_valid, rdata, rdata_last,
    output rdata_ready,
    input  done, err,
    input  mem_addr, mem_wdata, mem_acc_size, mem_wren, mem_en,
    output mem_rdata, mem_busy
  );
endinterface

// File: rtl/mem_burst_master.sv
// rtl/mem_burst_master.sv - burst initiator: line-buffered write fill, memory burst sequencing, read drain
module mem_burst_master #(
  parameter int unsigned                 ADDRESS_SIZE  = 32,
  parameter int unsigned                 DATA_SIZE     = 32,
  parameter logic [ADDRESS_SIZE-1:0]     START_ADDRESS = 32'h8002_0000,
  parameter int unsigned                 MEM_SIZE      = 1048578
) (
  input  logic               clk,
  input  logic               rst,
  mem_burst_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_WBURST,
    S_RBURST,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDRESS_SIZE:0] MEM_LIMIT = (ADDRESS_SIZE+1)'(MEM_SIZE);

  function automatic logic [4:0] burst_len(input logic [1:0] size);
    case (size)
      2'b00:   burst_len = 5'd1;
      2'b01:   burst_len = 5'd4;
      2'b10:   burst_len = 5'd8;
      default: burst_len = 5'd16;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [1:0]              size_q, size_d;
  logic                    wr_q, wr_d;
  logic                    rej_q, rej_d;
  logic [DATA_SIZE-1:0]    line_q [16];
  logic [DATA_SIZE-1:0]    line_d [16];

  logic [4:0]              last_idx;
  logic [ADDRESS_SIZE:0]   cmd_end;
  logic                    reject;

  // Range check is one bit wider than the address so offset + length cannot wrap.
  always_comb begin
    cmd_end  = {1'b0, bus.cmd_addr} - {1'b0, START_ADDRESS}
             + {{(ADDRESS_SIZE-6){1'b0}}, burst_len(bus.cmd_size), 2'b00};
    reject   = (bus.cmd_addr[1:0] != 2'b00) || (bus.cmd_addr < START_ADDRESS) ||
               (cmd_end > MEM_LIMIT);
    last_idx = burst_len(size_q) - 5'd1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wr_d    = wr_q;
    rej_d   = rej_q;
    line_d  = line_q;

    bus.cmd_ready    = 1'b0;
    bus.wdata_ready  = 1'b0;
    bus.rdata_valid  = 1'b0;
    bus.rdata        = '0;
    bus.rdata_last   = 1'b0;
    bus.done         = 1'b0;
    bus.err          = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.mem_acc_size = 2'b00;
    bus.mem_wren     = 1'b0;
    bus.mem_en       = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          size_d  = bus.cmd_size;
          wr_d    = bus.cmd_wr;
          rej_d   = reject;
          cnt_d   = 5'd0;
          if (reject) begin
            state_d = S_DONE;
          end else if (bus.cmd_wr) begin
            state_d = S_FILL;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      S_FILL: begin
        bus.wdata_ready = 1'b1;
        if (bus.wdata_valid) begin
          line_d[cnt_q[3:0]] = bus.wdata;
          if (cnt_q == last_idx) begin
            cnt_d   = 5'd0;
            state_d = S_ISSUE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      S_ISSUE: begin
        bus.mem_addr     = addr_q;
        bus.mem_acc_size = size_q;
        bus.mem_wren     = wr_q;
        bus.mem_wdata    = wr_q ? line_q[0] : '0;
        if (!bus.mem_busy) begin
          bus.mem_en = 1'b1;
          // Word 0 of a write goes out with mem_en, so a single-word write is already complete.
          if (wr_q) begin
            cnt_d   = 5'd1;
            state_d = (last_idx == 5'd0) ? S_DONE : S_WBURST;
          end else begin
            cnt_d   = 5'd0;
            state_d = S_RBURST;
          end
        end
      end

      S_WBURST: begin
        bus.mem_addr     = addr_q;
        bus.mem_acc_size = size_q;
        bus.mem_wren     = wr_q;
        bus.mem_wdata    = line_q[cnt_q[3:0]];
        if (cnt_q == last_idx) begin
          cnt_d   = 5'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_RBURST: begin
        // Memory returns word k one cycle after request cycle k, i.e. in RBURST cycle k.
        bus.mem_addr       = addr_q;
        bus.mem_acc_size   = size_q;
        bus.mem_wren       = wr_q;
        line_d[cnt_q[3:0]] = bus.mem_rdata;
        if (cnt_q == last_idx) begin
          cnt_d   = 5'd0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_DRAIN: begin
        bus.rdata_valid = 1'b1;
        bus.rdata       = line_q[cnt_q[3:0]];
        bus.rdata_last  = (cnt_q == last_idx);
        if (bus.rdata_ready) begin
          if (cnt_q == last_idx) begin
            cnt_d   = 5'd0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      S_DONE: begin
        bus.done = 1'b1;
        bus.err  = rej_q;
        cnt_d    = 5'd0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      wr_q    <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
      rej_q   <= rej_d;
    end
  end

  // Line buffer holds no control state, so it is left out of reset.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// tb/tb_mem_burst_master.sv - randomized self-checking bench for mem_burst_master
module tb_mem_burst_master;
  localparam logic [31:0] START    = 32'h8002_0000;
  localparam longint      MEM_SIZE = 1048578;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  logic [31:0] mem_store [int];
  logic [31:0] ref_mem   [int];

  mem_burst_master_if bus ();

  mem_burst_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_get(input int idx);
    return mem_store.exists(idx) ? mem_store[idx] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_get(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    return int'((longint'(a) - longint'(START)) >>> 2);
  endfunction

  function automatic int burst_words(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (2 << s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: one word per cycle, read word k presented in the cycle after request cycle k.
  initial begin : mem_model
    int          rd_left;
    int          wr_left;
    int          rd_idx;
    int          wr_idx;
    logic [31:0] b_addr;
    logic        prev_en;
    rd_left = 0;
    wr_left = 0;
    rd_idx  = 0;
    wr_idx  = 0;
    b_addr  = '0;
    prev_en = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_left = 0;
        wr_left = 0;
        prev_en = 1'b0;
      end else begin
        if (rd_left > 0) begin
          chk("rd_addr_hold", bus.mem_addr, b_addr);
          bus.mem_rdata = mem_get(rd_idx);
          rd_idx++;
          rd_left--;
        end else begin
          bus.mem_rdata = $urandom;
        end
        if (wr_left > 0) begin
          chk("wr_addr_hold", bus.mem_addr, b_addr);
          chk("wr_wren_hold", 32'(bus.mem_wren), 32'd1);
          mem_store[wr_idx] = bus.mem_wdata;
          wr_idx++;
          wr_left--;
        end
        if (bus.mem_en) begin
          chk("en_vs_busy", 32'(bus.mem_busy), 32'd0);
          chk("en_back2back", 32'(prev_en), 32'd0);
          b_addr = bus.mem_addr;
          if (bus.mem_wren) begin
            mem_store[word_idx(b_addr)] = bus.mem_wdata;
            wr_idx  = word_idx(b_addr) + 1;
            wr_left = burst_words(bus.mem_acc_size) - 1;
          end else begin
            rd_idx  = word_idx(b_addr);
            rd_left = burst_words(bus.mem_acc_size);
          end
        end
        prev_en = bus.mem_en;
      end
    end
  end

  // Runs one command from the IDLE cycle to its done pulse; expectations come from ref_mem and the latency rules.
  task automatic run_cmd(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                         input int rmode, input int busy_n, input bit wgaps,
                         input logic [31:0] wbase);
    int          n;
    longint      off;
    bit          rej;
    int          base;
    logic [31:0] exp_q [$];
    logic [31:0] wr_words [$];
    logic [31:0] w;
    int          t0, t_acc, t_done, t_en, en_cnt, widx, ridx, busy_left;
    bit          accepted, finished, held;
    logic [31:0] held_val;

    n    = burst_words(size);
    off  = longint'(addr) - longint'(START);
    rej  = (addr[1:0] != 2'b00) || (off < 0) || (off + longint'(4 * n) > MEM_SIZE);
    base = int'(off >>> 2);
    if (!rej) begin
      for (int i = 0; i < n; i++) begin
        if (wr) begin
          w = (wbase != 32'h0) ? wbase * 32'(i + 1) : $urandom;
          wr_words.push_back(w);
          ref_mem[base + i] = w;
        end else begin
          exp_q.push_back(ref_get(base + i));
        end
      end
    end

    t0 = cyc; t_acc = -1; t_done = -1; t_en = -1;
    en_cnt = 0; widx = 0; ridx = 0; busy_left = 0;
    accepted = 0; finished = 0; held = 0; held_val = '0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_wr    = wr;
    bus.cmd_size  = size;

    for (int c = 0; c < 400 && !finished; c++) begin
      bus.mem_busy = accepted && (busy_left > 0);
      if (accepted && busy_left > 0) busy_left--;
      bus.wdata_valid = wr && (widx < wr_words.size()) && (!wgaps || $urandom_range(0, 1) == 1);
      bus.wdata       = (widx < wr_words.size()) ? wr_words[widx] : 32'h0;
      bus.rdata_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? c[0] : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.mem_en) begin
        en_cnt++;
        t_en = cyc;
        chk("en_addr", bus.mem_addr, addr);
        chk("en_size", 32'(bus.mem_acc_size), 32'(size));
        chk("en_wren", 32'(bus.mem_wren), 32'(wr));
      end
      if (!accepted && bus.cmd_valid && bus.cmd_ready) begin
        accepted  = 1;
        t_acc     = cyc;
        busy_left = busy_n;
      end
      if (bus.wdata_valid && bus.wdata_ready) widx++;
      if (bus.rdata_valid) begin
        if (held) chk("rd_stall_hold", bus.rdata, held_val);
        if (bus.rdata_ready) begin
          if (ridx < exp_q.size()) chk("rdata", bus.rdata, exp_q[ridx]);
          else chk("rd_extra", 32'(ridx), 32'(exp_q.size()));
          chk("rd_last", 32'(bus.rdata_last), 32'(ridx == n - 1));
          ridx++;
          held = 0;
        end else begin
          held     = 1;
          held_val = bus.rdata;
        end
      end
      if (bus.done) begin
        finished = 1;
        t_done   = cyc;
        chk("err_flag", 32'(bus.err), 32'(rej));
        chk("done_no_ready", 32'(bus.cmd_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      if (accepted) bus.cmd_valid = 1'b0;
    end
    bus.cmd_valid   = 1'b0;
    bus.wdata_valid = 1'b0;
    bus.rdata_ready = 1'b0;
    bus.mem_busy    = 1'b0;

    chk("timeout", 32'(finished), 32'd1);
    chk("accept_first", 32'(t_acc), 32'(t0));
    if (rej) begin
      chk("rej_no_en", 32'(en_cnt), 32'd0);
      chk("rej_no_data", 32'(ridx), 32'd0);
      chk("rej_latency", 32'(t_done - t_acc), 32'd1);
    end else begin
      chk("en_once", 32'(en_cnt), 32'd1);
      if (!wr) begin
        chk("rd_en_cycle", 32'(t_en - t_acc), 32'(1 + busy_n));
        chk("rd_words", 32'(ridx), 32'(n));
        if (rmode == 0) chk("rd_latency", 32'(t_done - t_acc), 32'(2 * n + 2 + busy_n));
      end else begin
        if (!wgaps) begin
          chk("wr_en_cycle", 32'(t_en - t_acc), 32'(n + 1));
          chk("wr_latency", 32'(t_done - t_acc), 32'(2 * n + 1));
        end
        for (int i = 0; i < n; i++) chk("wr_mem", mem_get(base + i), wr_words[i]);
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic        rw;
    logic [1:0]  sz;
    int          t;

    rst = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_wr      = 1'b0;
    bus.cmd_size    = 2'b00;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    bus.rdata_ready = 1'b0;
    bus.mem_busy    = 1'b0;

    for (int i = 0; i < 64; i++) begin
      a = $urandom;
      mem_store[i] = a;
      ref_mem[i]   = a;
    end
    mem_store[0] = 32'hDEAD_BEEF;
    ref_mem[0]   = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_wren", 32'(bus.mem_wren), 32'd0);
    chk("rst_wdata_ready", 32'(bus.wdata_ready), 32'd0);
    chk("rst_rdata_valid", 32'(bus.rdata_valid), 32'd0);
    chk("rst_rdata_last", 32'(bus.rdata_last), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_acc_size", 32'(bus.mem_acc_size), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_cmd(START, 1'b0, 2'b00, 0, 0, 1'b0, 32'h0);
    run_cmd(START + 32'h10, 1'b1, 2'b01, 0, 0, 1'b0, 32'h1111_1111);
    run_cmd(START + 32'h10, 1'b0, 2'b01, 0, 0, 1'b0, 32'h0);
    run_cmd(START, 1'b0, 2'b11, 1, 0, 1'b0, 32'h0);

    run_cmd(32'h8002_0002, 1'b0, 2'b01, 0, 0, 1'b0, 32'h0);
    run_cmd(32'h8001_FFFC, 1'b0, 2'b01, 0, 0, 1'b0, 32'h0);
    run_cmd(START + 32'd1048576, 1'b0, 2'b01, 0, 0, 1'b0, 32'h0);
    run_cmd(START + 32'd1048576, 1'b1, 2'b00, 0, 0, 1'b0, 32'h0);
    run_cmd(START + 32'd1048560, 1'b0, 2'b01, 0, 0, 1'b0, 32'h0);
    run_cmd(START + 32'd1048572, 1'b1, 2'b00, 0, 0, 1'b0, 32'h0);
    run_cmd(START + 32'd1048572, 1'b0, 2'b00, 0, 0, 1'b0, 32'h0);

    run_cmd(START + 32'h40, 1'b0, 2'b10, 0, 5, 1'b0, 32'h0);

    // Reset in the third RBURST cycle of an 8-word read.
    bus.cmd_valid   = 1'b1;
    bus.cmd_addr    = START + 32'h40;
    bus.cmd_wr      = 1'b0;
    bus.cmd_size    = 2'b10;
    bus.rdata_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_accept", 32'(bus.cmd_ready), 32'd1);
    t = cyc;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_done", 32'(bus.done), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cycle", 32'(cyc - t), 32'd4);
    chk("mid_rst_in_burst", bus.mem_addr, START + 32'h40);
    chk("mid_rst_no_done2", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("post_rst_rdata_valid", 32'(bus.rdata_valid), 32'd0);
    chk("post_rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("post_rst_mem_wren", 32'(bus.mem_wren), 32'd0);
    chk("post_rst_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    bus.rdata_ready = 1'b0;
    run_cmd(START + 32'h8, 1'b0, 2'b00, 0, 0, 1'b0, 32'h0);

    for (int k = 0; k < 24; k++) begin
      a  = START + 32'($urandom_range(0, 40)) * 32'd4;
      if ($urandom_range(0, 7) == 0) a = a + 32'd2;
      sz = 2'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      run_cmd(a, rw, sz, int'($urandom_range(0, 2)), rw ? 0 : int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
